fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 78 +++++++
 tb/tb_fetch_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode.
// Circular buffer of {instr, pc} with flush and async active-low reset.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enq_valid_F,
  input  logic [31:0]   enq_instr_F,
  input  logic [63:0]   enq_pc_F,
  output logic          enq_ready_F,
  output logic          deq_valid_D,
  output logic [31:0]   deq_instr_D,
  output logic [63:0]   deq_pc_D,
  input  logic          deq_ready_D,
  input  logic          flush,
  output logic [AW:0]   count
);

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } fq_entry_t;

  fq_entry_t     mem [DEPTH];
  fq_entry_t     head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_enq;
  logic          do_deq;

  assign enq_ready_F = (count != (AW+1)'(DEPTH));
  assign deq_valid_D = (count != '0);

  assign do_enq = enq_valid_F && enq_ready_F && !flush;
  assign do_deq = deq_valid_D && deq_ready_D && !flush;

  assign head        = mem[rd_ptr];
  assign deq_instr_D = deq_valid_D ? head.instr : '0;
  assign deq_pc_D    = deq_valid_D ? head.pc    : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_enq) begin
      mem[wr_ptr] <= '{instr: enq_instr_F, pc: enq_pc_F};
    end
  end

  // Flush clears only pointers and count; storage is left as is.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_enq, do_deq})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue.
// Inputs change 1ns after the rising edge; outputs are sampled there.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        enq_valid_F;
  logic [31:0] enq_instr_F;
  logic [63:0] enq_pc_F;
  logic        enq_ready_F;
  logic        deq_valid_D;
  logic [31:0] deq_instr_D;
  logic [63:0] deq_pc_D;
  logic        deq_ready_D;
  logic        flush;
  logic [2:0]  count;

  int checks;
  int failures;

  fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .enq_valid_F (enq_valid_F),
    .enq_instr_F (enq_instr_F),
    .enq_pc_F    (enq_pc_F),
    .enq_ready_F (enq_ready_F),
    .deq_valid_D (deq_valid_D),
    .deq_instr_D (deq_instr_D),
    .deq_pc_D    (deq_pc_D),
    .deq_ready_D (deq_ready_D),
    .flush       (flush),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b0;
    enq_valid_F = 1'b0;
    enq_instr_F = '0;
    enq_pc_F    = '0;
    deq_ready_D = 1'b0;
    flush       = 1'b0;

    step();
    step();
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(deq_valid_D), 64'd0);
    check("rst_instr", 64'(deq_instr_D), 64'd0);
    check("rst_pc", deq_pc_D, 64'd0);
    check("rst_ready", 64'(enq_ready_F), 64'd1);
    reset = 1'b1;
    step();
    check("post_rst_count", 64'(count), 64'd0);
    check("post_rst_ready", 64'(enq_ready_F), 64'd1);

    // single entry, latency 1
    enq_valid_F = 1'b1;
    enq_instr_F = 32'h8B020020;
    enq_pc_F    = 64'h0;
    #1;
    check("single_no_bypass", 64'(deq_valid_D), 64'd0);
    step();
    enq_valid_F = 1'b0;
    check("single_valid", 64'(deq_valid_D), 64'd1);
    check("single_instr", 64'(deq_instr_D), 64'h8B020020);
    check("single_pc", deq_pc_D, 64'h0);
    check("single_count", 64'(count), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("single_flush", 64'(count), 64'd0);

    // fill to full
    for (int i = 0; i < 4; i++) begin
      enq_valid_F = 1'b1;
      enq_instr_F = 32'h1000 + 32'(i);
      enq_pc_F    = 64'(4 * i);
      step();
    end
    check("fill_count", 64'(count), 64'd4);
    check("fill_ready", 64'(enq_ready_F), 64'd0);
    enq_instr_F = 32'hDEAD;
    enq_pc_F    = 64'h10;
    step();
    check("fill_5th_ignored", 64'(count), 64'd4);
    enq_valid_F = 1'b0;
    deq_ready_D = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 64'(deq_valid_D), 64'd1);
      check("drain_pc", deq_pc_D, 64'(4 * i));
      check("drain_instr", 64'(deq_instr_D), 64'(32'h1000 + 32'(i)));
      step();
    end
    check("drain_empty", 64'(deq_valid_D), 64'd0);
    check("drain_count", 64'(count), 64'd0);

    // streaming through pointer wrap
    enq_valid_F = 1'b1;
    for (int i = 0; i < 10; i++) begin
      enq_pc_F    = 64'(4 * i);
      enq_instr_F = 32'h2000 + 32'(i);
      if (i > 0) begin
        check("stream_pc", deq_pc_D, 64'(4 * (i - 1)));
        check("stream_count", 64'(count), 64'd1);
      end
      step();
    end
    enq_valid_F = 1'b0;
    check("stream_last_pc", deq_pc_D, 64'h24);
    check("stream_last_instr", 64'(deq_instr_D), 64'h2009);
    step();
    check("stream_end_count", 64'(count), 64'd0);
    deq_ready_D = 1'b0;

    // full plus dequeue
    for (int i = 0; i < 4; i++) begin
      enq_valid_F = 1'b1;
      enq_pc_F    = 64'h200 + 64'(4 * i);
      enq_instr_F = 32'h3000 + 32'(i);
      step();
    end
    deq_ready_D = 1'b1;
    enq_pc_F    = 64'h300;
    enq_instr_F = 32'h3300;
    #1;
    check("fulldeq_ready", 64'(enq_ready_F), 64'd0);
    step();
    check("fulldeq_count", 64'(count), 64'd3);
    check("fulldeq_ready2", 64'(enq_ready_F), 64'd1);
    check("fulldeq_head", deq_pc_D, 64'h204);
    deq_ready_D = 1'b0;
    step();
    enq_valid_F = 1'b0;
    check("fulldeq_accept", 64'(count), 64'd4);
    deq_ready_D = 1'b1;
    step();
    deq_ready_D = 1'b0;
    check("pre_flush_count", 64'(count), 64'd3);
    check("pre_flush_head", deq_pc_D, 64'h208);

    // flush beats same-cycle enq/deq
    flush       = 1'b1;
    enq_valid_F = 1'b1;
    deq_ready_D = 1'b1;
    enq_pc_F    = 64'h500;
    step();
    flush       = 1'b0;
    enq_valid_F = 1'b0;
    deq_ready_D = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(deq_valid_D), 64'd0);
    check("flush_instr", 64'(deq_instr_D), 64'd0);
    check("flush_pc", deq_pc_D, 64'd0);
    enq_valid_F = 1'b1;
    enq_pc_F    = 64'h100;
    enq_instr_F = 32'h4100;
    step();
    enq_pc_F    = 64'h104;
    enq_instr_F = 32'h4104;
    check("after_flush_pc", deq_pc_D, 64'h100);
    check("after_flush_count", 64'(count), 64'd1);
    step();
    enq_valid_F = 1'b0;
    check("async_pre_count", 64'(count), 64'd2);

    // async reset mid-cycle
    #2;
    reset = 1'b0;
    #1;
    check("async_count", 64'(count), 64'd0);
    check("async_valid", 64'(deq_valid_D), 64'd0);
    check("async_pc", deq_pc_D, 64'd0);
    #1;
    reset = 1'b1;
    step();
    check("async_hold", 64'(count), 64'd0);
    enq_valid_F = 1'b1;
    enq_pc_F    = 64'h700;
    enq_instr_F = 32'h7700;
    step();
    enq_valid_F = 1'b0;
    check("post_async_pc", deq_pc_D, 64'h700);
    check("post_async_instr", 64'(deq_instr_D), 64'h7700);
    check("post_async_count", 64'(count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
